// File: rtl/multi_7_seg_scan_if.sv
// Interface for the multiplexed seven-segment scanner: digit data and strobes in, scan outputs back.
// master drives bcd/dp/load/blank and observes the segment/digit pins; slave is the scanner itself.
// Sized by DIGITS so the bus width always matches the scanner instance it is bound to.
interface multi_7_seg_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] bcd_i;
    logic [DIGITS-1:0]   dp_i;
    logic                load_i;
    logic                blank_lz_i;
    logic [6:0]          seg_o;
    logic                dp_o;
    logic [DIGITS-1:0]   dig_en_o;
    logic                frame_o;

    modport master (
        output bcd_i, dp_i, load_i, blank_lz_i,
        input  seg_o, dp_o, dig_en_o, frame_o
    );

    modport slave (
        input  bcd_i, dp_i, load_i, blank_lz_i,
        output seg_o, dp_o, dig_en_o, frame_o
    );
endinterface

// File: rtl/multi_7_seg_scan.sv
// Time-multiplexed driver for DIGITS seven-segment digits sharing one segment bus.
// Latency: outputs registered one cycle behind the scan counters; a load is visible within one frame + 1 cycle.
// Backpressure: none; load_i is always accepted, last load before a frame boundary wins.
// Define MULTI_7_SEG_HEX_EN to display values 10-15 as A..F; otherwise they show as a dash.
module multi_7_seg_scan #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multi_7_seg_scan_if.slave bus
);
    localparam int             PW   = $clog2(SCAN_DIV);
    localparam int             IW   = $clog2(DIGITS);
    localparam logic [PW-1:0]  PMAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]  IMAX = IW'(DIGITS - 1);
    // Physical level of an "off" segment/digit.
    localparam logic           OFF  = (ACTIVE_LOW != 0);

    logic [PW-1:0]       pcnt;
    logic [IW-1:0]       idx;
    logic                pend;
    logic [4*DIGITS-1:0] pend_bcd;
    logic [DIGITS-1:0]   pend_dp;
    logic [4*DIGITS-1:0] disp_bcd;
    logic [DIGITS-1:0]   disp_dp;
    logic                wrap_q;

    logic                slot_end;
    logic                wrap;
    logic [DIGITS-1:0]   blank;
    logic [3:0]          cur_val;
    logic [6:0]          seg_n;
    logic                dp_n;
    logic [DIGITS-1:0]   dig_n;

    // Logical segment pattern {a,b,c,d,e,f,g} for one BCD/hex value.
    function automatic logic [6:0] enc(input logic [3:0] v);
        enc = 7'b0000001;
        case (v)
            4'd0:  enc = 7'b1111110;
            4'd1:  enc = 7'b0110000;
            4'd2:  enc = 7'b1101101;
            4'd3:  enc = 7'b1111001;
            4'd4:  enc = 7'b0110011;
            4'd5:  enc = 7'b1011011;
            4'd6:  enc = 7'b1011111;
            4'd7:  enc = 7'b1110000;
            4'd8:  enc = 7'b1111111;
            4'd9:  enc = 7'b1111011;
`ifdef MULTI_7_SEG_HEX_EN
            4'd10: enc = 7'b1110111;
            4'd11: enc = 7'b0011111;
            4'd12: enc = 7'b1001110;
            4'd13: enc = 7'b0111101;
            4'd14: enc = 7'b1001111;
            4'd15: enc = 7'b1000111;
`endif
            default: ;
        endcase
    endfunction

    assign slot_end = (pcnt == PMAX);
    assign wrap     = slot_end && (idx == IMAX);

    // Prescaler and digit index; the idx wrap is the frame boundary.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (slot_end) begin
            pcnt <= '0;
            idx  <= wrap ? '0 : idx + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Pending/display buffers: the display only changes at a frame boundary so a frame never tears.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend     <= 1'b0;
            pend_bcd <= '0;
            pend_dp  <= '0;
            disp_bcd <= '0;
            disp_dp  <= '0;
        end else if (wrap) begin
            if (bus.load_i) begin
                disp_bcd <= bus.bcd_i;
                disp_dp  <= bus.dp_i;
            end else if (pend) begin
                disp_bcd <= pend_bcd;
                disp_dp  <= pend_dp;
            end
            pend <= 1'b0;
        end else if (bus.load_i) begin
            pend_bcd <= bus.bcd_i;
            pend_dp  <= bus.dp_i;
            pend     <= 1'b1;
        end
    end

    // Leading-zero mask: digit k blanks when it and every digit above it is 0 with no dp; digit 0 never blanks.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank      = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (disp_bcd[4*k +: 4] == 4'd0) && !disp_dp[k];
            blank[k]   = bus.blank_lz_i && zero_above;
        end
    end

    // Logical output levels for the current slot; all digits off in the first cycle of a slot.
    always_comb begin
        cur_val = disp_bcd[{idx, 2'b00} +: 4];
        seg_n   = blank[idx] ? 7'd0 : enc(cur_val);
        dp_n    = !blank[idx] && disp_dp[idx];
        dig_n   = '0;
        if (pcnt != '0) begin
            dig_n[idx] = 1'b1;
        end
    end

    // Output registers with polarity applied; frame_o lines up with the digit 0 ghost gap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.seg_o    <= {7{OFF}};
            bus.dp_o     <= OFF;
            bus.dig_en_o <= {DIGITS{OFF}};
            bus.frame_o  <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            bus.seg_o    <= seg_n ^ {7{OFF}};
            bus.dp_o     <= dp_n ^ OFF;
            bus.dig_en_o <= dig_n ^ {DIGITS{OFF}};
            wrap_q       <= wrap;
            bus.frame_o  <= wrap_q;
        end
    end
endmodule

// File: tb/tb_multi_7_seg_scan.sv
// Bench for multi_7_seg_scan: DIGITS=4, SCAN_DIV=4, one active-high and one active-low instance.
// Hand sequences cover reset/first scan, frame-synchronous and boundary loads, mid-frame reset.
// A table of display vectors feeds a scoreboard checked as each digit slot comes up.
module tb_multi_7_seg_scan;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    localparam logic [6:0] OFF = 7'b0000000;
    localparam logic [6:0] S0  = 7'b1111110;
    localparam logic [6:0] S1  = 7'b0110000;
    localparam logic [6:0] S2  = 7'b1101101;
    localparam logic [6:0] S3  = 7'b1111001;
    localparam logic [6:0] S4  = 7'b0110011;
    localparam logic [6:0] S5  = 7'b1011011;
    localparam logic [6:0] S6  = 7'b1011111;
    localparam logic [6:0] S7  = 7'b1110000;
    localparam logic [6:0] S8  = 7'b1111111;
    localparam logic [6:0] S9  = 7'b1111011;
`ifdef MULTI_7_SEG_HEX_EN
    localparam logic [6:0] SA  = 7'b1110111;
    localparam logic [6:0] SE  = 7'b1001111;
    localparam logic [6:0] SF  = 7'b1000111;
`else
    localparam logic [6:0] SA  = 7'b0000001;
    localparam logic [6:0] SE  = 7'b0000001;
    localparam logic [6:0] SF  = 7'b0000001;
`endif

    typedef struct {
        logic [15:0]     bcd;
        logic [3:0]      dp;
        logic            blz;
        logic [3:0][6:0] seg;
        logic [3:0]      dpo;
    } vec_t;

    typedef struct {
        int         dig;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    vec_t vt[10];

    always #5 clk_i = ~clk_i;

    multi_7_seg_scan_if #(.DIGITS(DIGITS)) bus ();
    multi_7_seg_scan_if #(.DIGITS(DIGITS)) bus_l ();

    assign bus_l.bcd_i      = bus.bcd_i;
    assign bus_l.dp_i       = bus.dp_i;
    assign bus_l.load_i     = bus.load_i;
    assign bus_l.blank_lz_i = bus.blank_lz_i;

    multi_7_seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(0)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    multi_7_seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1)) dut_l (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_frame(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (bus.frame_o === 1'b1) seen = 1'b1;
        end
        check({name, "_frame_seen"}, 32'(seen), 32'd1);
    endtask

    // Advance to the next cycle where digit k is enabled, then check its segments on both instances.
    task automatic check_digit(input string name, input int k, input logic [6:0] seg, input logic dp);
        logic       seen;
        logic [3:0] en;
        logic [6:0] seg_inv;
        logic       dp_inv;
        en      = 4'(1 << k);
        seg_inv = ~seg;
        dp_inv  = ~dp;
        seen    = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (bus.dig_en_o === en) seen = 1'b1;
        end
        check({name, "_slot_seen"}, 32'(seen), 32'd1);
        check({name, "_seg"}, 32'(bus.seg_o), 32'(seg));
        check({name, "_dp"}, 32'(bus.dp_o), 32'(dp));
        check({name, "_seg_l"}, 32'(bus_l.seg_o), 32'(seg_inv));
        check({name, "_dp_l"}, 32'(bus_l.dp_o), 32'(dp_inv));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t;
        exp_t       e;
        logic [3:0] want_en;
        logic [3:0] en_inv;
        logic [6:0] seg_inv;
        logic       dp_inv;

        vt[0] = '{16'h0050, 4'b0000, 1'b1, {OFF, OFF, S5, S0}, 4'b0000};
        vt[1] = '{16'h0050, 4'b0100, 1'b1, {OFF, S0,  S5, S0}, 4'b0100};
        vt[2] = '{16'h00AF, 4'b0000, 1'b0, {S0,  S0,  SA, SF}, 4'b0000};
        vt[3] = '{16'h6789, 4'b1000, 1'b0, {S6,  S7,  S8, S9}, 4'b1000};
        vt[4] = '{16'h0000, 4'b0000, 1'b1, {OFF, OFF, OFF, S0}, 4'b0000};
        vt[5] = '{16'h0000, 4'b0001, 1'b1, {OFF, OFF, OFF, S0}, 4'b0001};
        vt[6] = '{16'h1000, 4'b0000, 1'b1, {S1,  S0,  S0, S0}, 4'b0000};
        vt[7] = '{16'h00E0, 4'b0000, 1'b1, {OFF, OFF, SE, S0}, 4'b0000};
        vt[8] = '{16'h5432, 4'b0000, 1'b0, {S5,  S4,  S3, S2}, 4'b0000};
        vt[9] = '{16'h0500, 4'b0000, 1'b1, {OFF, S5,  S0, S0}, 4'b0000};

        rst_i          = 1'b1;
        bus.load_i     = 1'b0;
        bus.bcd_i      = '0;
        bus.dp_i       = '0;
        bus.blank_lz_i = 1'b0;
        tick();
        tick();

        // Reset levels on both polarities.
        check("rst_seg", 32'(bus.seg_o), 32'h00);
        check("rst_dp", 32'(bus.dp_o), 32'h0);
        check("rst_dig", 32'(bus.dig_en_o), 32'h0);
        check("rst_frame", 32'(bus.frame_o), 32'h0);
        check("rst_seg_l", 32'(bus_l.seg_o), 32'h7F);
        check("rst_dp_l", 32'(bus_l.dp_o), 32'h1);
        check("rst_dig_l", 32'(bus_l.dig_en_o), 32'hF);
        check("rst_frame_l", 32'(bus_l.frame_o), 32'h0);

        // First scan: one ghost cycle, then digit 0 for three cycles.
        rst_i = 1'b0;
        tick();
        check("first_ghost_dig", 32'(bus.dig_en_o), 32'h0);
        check("first_ghost_frame", 32'(bus.frame_o), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("scan_d0_en", 32'(bus.dig_en_o), 32'b0001);
            check("scan_d0_seg", 32'(bus.seg_o), 32'(S0));
            check("scan_d0_en_l", 32'(bus_l.dig_en_o), 32'b1110);
        end
        tick();
        check("ghost_d1", 32'(bus.dig_en_o), 32'h0);
        t = 5;
        while (t < 40 && bus.frame_o !== 1'b1) begin
            tick();
            t++;
        end
        check("first_frame_cycle", 32'(t), 32'd17);
        check("frame_ghost", 32'(bus.dig_en_o), 32'h0);
        tick();
        check("frame_width", 32'(bus.frame_o), 32'h0);
        t = 1;
        while (t < 40 && bus.frame_o !== 1'b1) begin
            tick();
            t++;
        end
        check("frame_period", 32'(t), 32'd16);

        // Mid-frame load: current frame keeps old data, next frame shows the load.
        repeat (6) tick();
        bus.bcd_i  = 16'h1234;
        bus.load_i = 1'b1;
        tick();
        bus.load_i = 1'b0;
        check_digit("fs_old_d3", 3, S0, 1'b0);
        wait_frame("fs");
        check_digit("fs_new_d0", 0, S4, 1'b0);
        check_digit("fs_new_d3", 3, S1, 1'b0);

        // Load sampled on the boundary edge shows in the frame that starts there.
        wait_frame("bnd_pre");
        repeat (14) tick();
        bus.bcd_i  = 16'h5678;
        bus.load_i = 1'b1;
        tick();
        bus.load_i = 1'b0;
        tick();
        check("bnd_frame", 32'(bus.frame_o), 32'h1);
        check_digit("bnd_d0", 0, S8, 1'b0);
        check_digit("bnd_d3", 3, S5, 1'b0);

        // Reset while idx=2 with a load pending; a load in the reset cycle is ignored.
        wait_frame("mr_pre");
        repeat (6) tick();
        bus.bcd_i  = 16'h9999;
        bus.load_i = 1'b1;
        tick();
        bus.load_i = 1'b0;
        tick();
        rst_i      = 1'b1;
        bus.bcd_i  = 16'h8888;
        bus.load_i = 1'b1;
        tick();
        check("mr_seg", 32'(bus.seg_o), 32'h00);
        check("mr_dig", 32'(bus.dig_en_o), 32'h0);
        check("mr_dp", 32'(bus.dp_o), 32'h0);
        check("mr_frame", 32'(bus.frame_o), 32'h0);
        check("mr_seg_l", 32'(bus_l.seg_o), 32'h7F);
        check("mr_dig_l", 32'(bus_l.dig_en_o), 32'hF);
        rst_i      = 1'b0;
        bus.load_i = 1'b0;
        bus.bcd_i  = '0;
        wait_frame("mr");
        for (int k = 0; k < DIGITS; k++) begin
            check_digit($sformatf("mr_d%0d", k), k, S0, 1'b0);
        end

        // Table vectors through the scoreboard.
        for (int v = 0; v < 10; v++) begin
            wait_frame($sformatf("v%0d_pre", v));
            repeat (5) tick();
            bus.bcd_i      = vt[v].bcd;
            bus.dp_i       = vt[v].dp;
            bus.blank_lz_i = vt[v].blz;
            bus.load_i     = 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
                sb.push_back('{k, vt[v].seg[k], vt[v].dpo[k]});
            end
            tick();
            bus.load_i = 1'b0;
            wait_frame($sformatf("v%0d", v));
            for (int c = 0; c < DIGITS * SCAN_DIV; c++) begin
                tick();
                if (sb.size() > 0) begin
                    want_en = 4'(1 << sb[0].dig);
                    if (bus.dig_en_o === want_en) begin
                        e       = sb.pop_front();
                        seg_inv = ~e.seg;
                        dp_inv  = ~e.dp;
                        en_inv  = ~want_en;
                        check($sformatf("v%0d_d%0d_seg", v, e.dig), 32'(bus.seg_o), 32'(e.seg));
                        check($sformatf("v%0d_d%0d_dp", v, e.dig), 32'(bus.dp_o), 32'(e.dp));
                        check($sformatf("v%0d_d%0d_seg_l", v, e.dig), 32'(bus_l.seg_o), 32'(seg_inv));
                        check($sformatf("v%0d_d%0d_dp_l", v, e.dig), 32'(bus_l.dp_o), 32'(dp_inv));
                        check($sformatf("v%0d_d%0d_en_l", v, e.dig), 32'(bus_l.dig_en_o), 32'(en_inv));
                    end
                end
            end
            check($sformatf("v%0d_drain", v), 32'(sb.size()), 32'd0);
            sb.delete();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multi_7_seg_scan.md
# multi_7_seg_scan

Time-multiplexed driver for a row of `DIGITS` seven-segment digits sharing one segment bus. It is the parametrised successor to the two-digit static encoder in the scoreboard display path. It scans digits at a programmable rate and adds per-digit decimal points, leading-zero blanking, inter-digit ghost blanking and tear-free frame-synchronous updates. It sits between the score/BCD logic and the board's digit-select and segment pins.

## Interface
Parameters:
- `DIGITS`, 4: number of digits, ≥2; digit 0 is least significant.
- `SCAN_DIV`, 1000: clock cycles per digit slot, ≥2.
- `ACTIVE_LOW`, 0: 0 means a segment or digit is on when its output is high; 1 inverts all of `seg_o`, `dp_o` and `dig_en_o`.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `bcd_i`, in, 4*DIGITS: digit values; digit k is `bcd_i[4k+3:4k]`.
- `dp_i`, in, DIGITS: decimal point request per digit.
- `load_i`, in, 1: one-cycle strobe that captures `bcd_i`/`dp_i`.
- `blank_lz_i`, in, 1: enable leading-zero blanking.
- `seg_o`, out, 7: segments {a,b,c,d,e,f,g}, registered.
- `dp_o`, out, 1: decimal point segment, registered.
- `dig_en_o`, out, DIGITS: one-hot digit enable, registered.
- `frame_o`, out, 1: one-cycle pulse at each frame boundary.

## Operation
Encoding, logical (before polarity):
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
- Values 10–15 are covered under Configuration.

Registers:
- Prescaler `pcnt` counts 0..SCAN_DIV-1.
- Digit index `idx` counts 0..DIGITS-1.
- Pending buffer plus `pend` flag.
- Display buffer.

Scan:
- When `pcnt`=SCAN_DIV-1, `pcnt`→0 and `idx` advances.
- `idx` wraps from DIGITS-1 to 0. This wrap is the frame boundary.

Load and frame update:
- A `load_i` pulse writes `bcd_i`/`dp_i` to the pending buffer and sets `pend`. A later load overwrites the earlier one; last load wins.
- At the frame boundary with `pend`=1, the pending buffer is copied to the display buffer and `pend` is cleared.
- If `load_i` is high in the boundary cycle, `bcd_i`/`dp_i` go straight to the display buffer and `pend` is cleared.
- The display buffer never changes mid-frame.

Output selection for the current `idx`:
- Segments: encode the display digit at `idx`; drive `dp_o` from the dp bit of that digit.
- Leading-zero blanking: when `blank_lz_i`=1, digit k is blanked (segments and dp off) if every display digit j≥k is 0 and has dp=0. Digit 0 is never blanked.
- Digit enable: `dig_en_o` enables bit `idx`, except in the first cycle of each slot (`pcnt`=0), when all digits are off. This is the ghost gap.

## Timing
Reset, applied on any edge where `rst_i`=1, including mid-frame. On the following edge:
- `pcnt`=0, `idx`=0, `pend`=0.
- Pending and display buffers all 0, dp all 0.
- `seg_o`, `dp_o`, `dig_en_o` at physical off levels: all 0 if ACTIVE_LOW=0, all 1 if ACTIVE_LOW=1.
- `frame_o`=0.

After reset release:
- All outputs are registered with 1-cycle latency from `pcnt`/`idx`. The first edge with `rst_i`=0 leaves `dig_en_o` all-off (ghost gap). Digit 0 is enabled from the second edge.
- Slot length is SCAN_DIV cycles; frame length is DIGITS×SCAN_DIV cycles.
- `frame_o` is high for exactly one cycle, in the same cycle the display buffer takes new data and the digit 0 ghost gap appears on the outputs.
- Load-to-display latency is at most one frame plus 1 cycle.
- `load_i` asserted in the same cycle as `rst_i` is ignored.

## Configuration
Macro `MULTI_7_SEG_HEX_EN`:
- Defined: values 10–15 display A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Undefined: values 10–15 display "-"=0000001.
- Leading-zero blanking treats only value 0 as zero in both builds.

## Test plan
- **Reset and first scan** (DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=0): release reset → `dig_en_o`=0000 for 1 cycle, then 0001 for 3 cycles, `seg_o`=1111110; `frame_o` pulses every 16 cycles.
- **Frame-synchronous load**: load 0x1234 mid-frame → digit 3 shows 0110000 only after the next `frame_o`; the current frame still shows 0. A load in the boundary cycle shows in that frame.
- **Leading-zero blanking**: display 0x0050, `blank_lz_i`=1 → digits 3 and 2 segments off, digit 1 shows 1011011, digit 0 shows 1111110. With dp on digit 2, digit 2 shows 1111110 with `dp_o`=1.
- **Hex macro**: display 0x00AF → with the macro, 1110111/1000111; without it, 0000001 on both digits.
- **ACTIVE_LOW=1**: all output levels inverted; reset drives `seg_o`=1111111, `dig_en_o`=1111.
- **Mid-frame reset**: assert `rst_i` while `idx`=2 with a pending load → next edge all outputs off, `pend` cleared, display 0 after restart.
